i2c_target_regfile: RTL
=======================

# i2c_target_regfile

I2C target (slave) that answers the I2C master on the same two-wire bus. It exposes an 8-bit register bank to a remote I2C master: the master writes a register pointer, then writes or reads data bytes with pointer auto-increment. Register contents are presented in parallel to local logic, and a write strobe flags every update.

## Interface
- `I2C_ADDR`, default `7'h42`: 7-bit target address this block answers to.
- `PTR_W`, default `3`: pointer width. The bank holds `NREGS = 2**PTR_W` registers.
- `clk`  input  1  system clock. Must be at least 16× the SCL frequency.
- `rst`  input  1  asynchronous reset, active-low.
- `scl`  input  1  I2C clock. The block never stretches SCL.
- `sda`  inout  1  I2C data, open-drain. The block drives only `1'b0`, otherwise `1'bz`.
- `regs_o`  output  `8*NREGS`  flattened bank. Register k is at bits `[8k+7:8k]`.
- `wr_pulse`  output  1  one-cycle pulse when a data byte is committed to the bank.
- `wr_idx`  output  `PTR_W`  index of the register committed. Valid while `wr_pulse` is high.
- `busy`  output  1  high from a START with address match until STOP or NACK termination.

## Operation
- **Input sync:** `scl` and the `sda` input each pass through a 2-FF synchronizer. A third register holds the previous value for edge detection.
  - SCL rise and SCL fall events are derived from the synchronized values.
  - START = synchronized SDA falls while synchronized SCL is high. STOP = SDA rises while SCL is high.
- **STOP:** from any state, returns to IDLE, releases SDA and clears `busy`.
- **START (including repeated START):** from any state, goes to ADDR with the bit counter cleared and SDA released. The pointer is kept.
- **Shift register:** 8-bit, MSB first. Sampled on SCL rise. Bit counter runs 0..7.
- **FSM states:** IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, WAIT_STOP.
  - ADDR: after 8 bits, if `byte[7:1]==I2C_ADDR`, go to ADDR_ACK and latch the R/W bit; otherwise go to WAIT_STOP (no ACK).
  - ADDR_ACK: ACK is driven over one SCL high period. Next state is RDATA if R/W=1, otherwise PTR.
  - PTR: after 8 bits, pointer ← `byte[PTR_W-1:0]`, then PTR_ACK. PTR_ACK is followed by WDATA.
  - WDATA: after 8 bits, `regs[ptr]` ← byte, pulse `wr_pulse` with `wr_idx=ptr`, increment ptr, go to WDATA_ACK. WDATA_ACK returns to WDATA.
  - RDATA: on entry, load the shifter from `regs[ptr]`. Present bits MSB first. After 8 bits, increment ptr and go to RDATA_ACK.
  - RDATA_ACK: sample master SDA on SCL rise. 0 (ACK) → RDATA (reload). 1 (NACK) → WAIT_STOP.
  - WAIT_STOP: SDA released. Leaves only on START or STOP.
- **SDA drive rules:**
  - SDA drive changes only on a detected SCL fall, so the previous value is held through the whole SCL high period.
  - ACK is asserted on the SCL fall ending bit 8 and released on the following SCL fall.
  - Read data follows the same rule: driving low for a 0 bit, released for a 1 bit.
- **Pointer:** wraps modulo `NREGS`. Pointer bits above `PTR_W` are ignored.
- Local logic cannot write the bank. `regs_o` is the registered bank.

## Timing
- **Reset values:** `regs_o=0`, pointer 0, `sda`=Z, `wr_pulse=0`, `wr_idx=0`, `busy=0`, FSM=IDLE, synchronizers=1.
- **Reset mid-transfer:** SDA is released immediately (asynchronous) and the bank is cleared. A partially shifted byte is discarded.
- **Detection latency:** pin change → internal event = 3 `clk` edges. Pin → SDA drive change ≤ 4 cycles after the SCL fall.
- **Write latency:** `wr_pulse` and `regs_o` update happen in the same cycle, 1 cycle after the 8th SCL rise event of a WDATA byte.
- **Busy:** rises 1 cycle after the address-match decision.
- **Simultaneous events:** START/STOP take priority over SCL edge processing in the same cycle. SDA changes while SCL is high are never treated as data.
- **Aborted byte:** a STOP or START mid-byte aborts it, with no bank write and no pointer change.

## Test plan
- Addressed write: S, `0x84`(0x42,W), ptr `0x02`, data `0xA5`,`0x3C`, P → ACK on all 4 bytes; `regs[2]=0xA5`, `regs[3]=0x3C`; two `wr_pulse` with `wr_idx` 2 then 3.
- Read with repeated START: S, `0x84`, ptr `0x02`, Sr, `0x85`, master ACK then NACK, P → bytes `0xA5`,`0x3C` returned; SDA released after NACK; `busy` falls at P.
- Address mismatch: S, `0x90`, `0x11`, P → SDA never driven low; no `wr_pulse`; `busy` stays 0.
- Pointer wrap (PTR_W=3): write ptr `0x07`, data `0x11`,`0x22` → `regs[7]=0x11`, `regs[0]=0x22`.
- Abort: STOP after 4 data bits → no write, FSM IDLE. A following full write still succeeds.
- Reset mid-read (`rst`=0 while driving a 0 bit) → SDA=Z in the same cycle, `regs_o=0`; after release the next transaction is ACKed normally.

Source files
------------

// File: rtl/i2c_target_regfile.sv
// i2c_target_regfile: I2C target exposing a pointer-addressed 8-bit register bank
`timescale 1ns/1ps
module i2c_target_regfile #(
    parameter logic [6:0] I2C_ADDR = 7'h42,
    parameter int         PTR_W    = 3
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      scl,
    inout  wire                       sda,
    output logic [8*(2**PTR_W)-1:0]   regs_o,
    output logic                      wr_pulse,
    output logic [PTR_W-1:0]          wr_idx,
    output logic                      busy
);
    localparam int NREGS = 2**PTR_W;

    typedef enum logic [3:0] {
        IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, WAIT_STOP
    } state_t;

    state_t           r_state, w_next;
    logic             r_scl_s1, r_scl_s2, r_scl_d;
    logic             r_sda_s1, r_sda_s2, r_sda_d;
    logic [7:0]       r_shift;
    logic [2:0]       r_cnt;
    logic [PTR_W-1:0] r_ptr;
    logic             r_drv, r_phase, r_load, r_rw, r_busy;
    logic             r_wr_pulse;
    logic [PTR_W-1:0] r_wr_idx;
    logic [7:0]       r_bank [NREGS];

    logic             w_scl_rise, w_scl_fall, w_start, w_stop, w_last, w_match;
    logic [7:0]       w_byte, w_cur;

    assign w_scl_rise = r_scl_s2 && !r_scl_d;
    assign w_scl_fall = !r_scl_s2 && r_scl_d;
    assign w_start    = r_scl_s2 && r_scl_d && !r_sda_s2 && r_sda_d;
    assign w_stop     = r_scl_s2 && r_scl_d && r_sda_s2 && !r_sda_d;
    assign w_byte     = {r_shift[6:0], r_sda_s2};
    assign w_last     = w_scl_rise && (r_cnt == 3'd7);
    assign w_match    = (w_byte[7:1] == I2C_ADDR);
    assign w_cur      = r_bank[r_ptr];

    assign sda      = r_drv ? 1'b0 : 1'bz;
    assign wr_pulse = r_wr_pulse;
    assign wr_idx   = r_wr_idx;
    assign busy     = r_busy;

    for (genvar k = 0; k < NREGS; k++) begin : g_out
        assign regs_o[8*k +: 8] = r_bank[k];
    end

    // Two-stage synchronizers plus a delayed copy for edge detection
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_scl_s1 <= 1'b1;
            r_scl_s2 <= 1'b1;
            r_scl_d  <= 1'b1;
            r_sda_s1 <= 1'b1;
            r_sda_s2 <= 1'b1;
            r_sda_d  <= 1'b1;
        end else begin
            r_scl_s1 <= scl;
            r_scl_s2 <= r_scl_s1;
            r_scl_d  <= r_scl_s2;
            r_sda_s1 <= sda;
            r_sda_s2 <= r_sda_s1;
            r_sda_d  <= r_sda_s2;
        end
    end

    // Protocol state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= IDLE;
        else      r_state <= w_next;
    end

    // Next state: bus conditions override bit-level progress; ACK slots end on their second SCL fall
    always_comb begin
        w_next = r_state;
        if (w_stop) w_next = IDLE;
        else if (w_start) w_next = ADDR;
        else begin
            case (r_state)
                ADDR:      if (w_last) w_next = w_match ? ADDR_ACK : WAIT_STOP;
                ADDR_ACK:  if (w_scl_fall && r_phase) w_next = r_rw ? RDATA : PTR;
                PTR:       if (w_last) w_next = PTR_ACK;
                PTR_ACK:   if (w_scl_fall && r_phase) w_next = WDATA;
                WDATA:     if (w_last) w_next = WDATA_ACK;
                WDATA_ACK: if (w_scl_fall && r_phase) w_next = WDATA;
                RDATA:     if (w_last) w_next = RDATA_ACK;
                RDATA_ACK: if (w_scl_rise) w_next = r_sda_s2 ? WAIT_STOP : RDATA;
                default:   w_next = r_state;
            endcase
        end
    end

    // Shifter, bit counter, pointer, SDA drive and status flags
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_shift    <= '0;
            r_cnt      <= '0;
            r_ptr      <= '0;
            r_drv      <= 1'b0;
            r_phase    <= 1'b0;
            r_load     <= 1'b0;
            r_rw       <= 1'b0;
            r_busy     <= 1'b0;
            r_wr_pulse <= 1'b0;
            r_wr_idx   <= '0;
        end else begin
            r_wr_pulse <= 1'b0;
            if (w_stop) begin
                r_drv  <= 1'b0;
                r_busy <= 1'b0;
            end else if (w_start) begin
                r_drv   <= 1'b0;
                r_cnt   <= '0;
                r_phase <= 1'b0;
                r_load  <= 1'b0;
            end else begin
                case (r_state)
                    ADDR: if (w_scl_rise) begin
                        r_shift <= w_byte;
                        r_cnt   <= r_cnt + 1'b1;
                        if (r_cnt == 3'd7) begin
                            r_rw    <= w_byte[0];
                            r_phase <= 1'b0;
                            if (w_match) r_busy <= 1'b1;
                        end
                    end
                    PTR: if (w_scl_rise) begin
                        r_shift <= w_byte;
                        r_cnt   <= r_cnt + 1'b1;
                        if (r_cnt == 3'd7) begin
                            r_ptr   <= w_byte[PTR_W-1:0];
                            r_phase <= 1'b0;
                        end
                    end
                    WDATA: if (w_scl_rise) begin
                        r_shift <= w_byte;
                        r_cnt   <= r_cnt + 1'b1;
                        if (r_cnt == 3'd7) begin
                            r_wr_pulse <= 1'b1;
                            r_wr_idx   <= r_ptr;
                            r_ptr      <= r_ptr + 1'b1;
                            r_phase    <= 1'b0;
                        end
                    end
                    ADDR_ACK, PTR_ACK, WDATA_ACK: if (w_scl_fall) begin
                        r_phase <= 1'b1;
                        r_drv   <= !r_phase || (r_state == ADDR_ACK && r_rw && !w_cur[7]);
                        r_shift <= {w_cur[6:0], 1'b0};
                    end
                    RDATA: begin
                        if (w_scl_rise) begin
                            r_cnt <= r_cnt + 1'b1;
                            if (r_cnt == 3'd7) r_ptr <= r_ptr + 1'b1;
                        end
                        if (w_scl_fall) begin
                            r_drv   <= r_load ? !w_cur[7] : !r_shift[7];
                            r_shift <= r_load ? {w_cur[6:0], 1'b0} : {r_shift[6:0], 1'b0};
                            r_load  <= 1'b0;
                        end
                    end
                    RDATA_ACK: begin
                        if (w_scl_fall) r_drv <= 1'b0;
                        if (w_scl_rise) begin
                            r_load <= !r_sda_s2;
                            if (r_sda_s2) r_busy <= 1'b0;
                        end
                    end
                    default: r_drv <= 1'b0;
                endcase
            end
        end
    end

    // Register bank, written only by a completed WDATA byte
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREGS; i++) r_bank[i] <= '0;
        end else if (!w_stop && !w_start && r_state == WDATA && w_last) begin
            r_bank[r_ptr] <= w_byte;
        end
    end
endmodule
